txd_arbiter: RTL and testbench
==============================

// Module: txd_arbiter
// PURPOSE
//   Shares the single par8 byte transmitter between NUM_REQ requesters (cmd_parser,
//   status/debug reporters). Grants one requester at a time and locks the grant for a
//   whole packet (through req_last). Arbitration between packets is round-robin.
//   A starving grant is aborted after a timeout so a hung source cannot block the link.
// PARAMETERS
//   NUM_REQ         2   number of requesters, 2..8
//   TIMEOUT_CYCLES  0   mid-packet starvation limit in clk cycles; 0 disables timeout
// PORTS
//   clk            in   1          system clock
//   reset          in   1          synchronous, active-high reset
//   req_valid      in   NUM_REQ    requester i has a byte on req_data[8i+7:8i]
//   req_data       in   8*NUM_REQ  packed request bytes
//   req_last       in   NUM_REQ    byte presented by i is last of its packet
//   req_ready      out  NUM_REQ    byte of i accepted this cycle (combinational)
//   txd_ready_next in   1          transmitter can take a byte next cycle
//   txd_start      out  1          one-cycle start pulse to transmitter (registered)
//   txd_data       out  8          byte to transmit (registered, valid with txd_start)
//   grant          out  NUM_REQ    one-hot current owner; 0 when idle
//   busy           out  1          1 while a packet is locked (state != IDLE)
//   pkt_done       out  1          one-cycle pulse after last byte of a packet issued
//   err_timeout    out  1          one-cycle pulse when a grant is aborted by timeout
// BEHAVIOUR
//   Reset: txd_start=0, txd_data=8'h00, grant=0, busy=0, pkt_done=0, err_timeout=0,
//     state=IDLE, timeout counter=0, last_grant=NUM_REQ-1 (so req 0 has first priority).
//   States: IDLE, SEND, GAP.
//   IDLE: txd_start<=0. If any req_valid: search from (last_grant+1) mod NUM_REQ
//     upward with wrap; first set bit wins; grant<=winner, last_grant<=winner, ->SEND.
//     No byte is accepted in the arbitration cycle (1 cycle arbitration latency).
//   SEND: req_ready[g] = req_valid[g] & txd_ready_next; all other req_ready bits 0.
//     On acceptance: txd_data<=req_data[g], txd_start<=1, timeout counter<=0, ->GAP;
//     if req_last[g] also set, record end-of-packet.
//     Else txd_start<=0; if txd_ready_next=1 and req_valid[g]=0 counter increments;
//     transmitter back-pressure (txd_ready_next=0) never counts toward timeout.
//     Counter reaching TIMEOUT_CYCLES (nonzero): err_timeout pulse, grant<=0, ->IDLE.
//   GAP: txd_start<=0, req_ready all 0 (one idle cycle between bytes, lets
//     txd_ready_next fall). If end-of-packet recorded: pkt_done pulse, grant<=0,
//     ->IDLE; else ->SEND.
//   Accepted byte appears on txd_data/txd_start exactly 1 cycle after req_ready.
//   Max throughput: 1 byte per 2 cycles while txd_ready_next held high.
//   Requests from non-granted sources are held off (req_ready=0) until packet end;
//   they are not lost; requester must hold req_valid/data/last until req_ready.
//   A requester dropping req_valid mid-packet keeps the grant (until timeout).
//   req_last with req_valid=0 is ignored. Single-byte packet: valid+last together.
//   Reset mid-packet: next cycle txd_start=0, grant=0, IDLE; partial packet dropped.
//   Timeout counter width: clog2(TIMEOUT_CYCLES+1), never wraps.
// TESTING
//   1 req0 sends 8'hA1,A2,A3(last), txd_ready_next=1 -> txd_start pulses on 3 cycles
//     2 apart, txd_data A1,A2,A3; pkt_done 1 cycle after A3's GAP; grant=0 after.
//   2 req0 and req1 both valid in cycle after reset, 2-byte packets -> req0 bytes
//     sent first, then req1; repeat contention -> req1 wins (round-robin).
//   3 txd_ready_next=0 for 50 cycles mid-packet, TIMEOUT_CYCLES=16 -> no txd_start,
//     no err_timeout; packet resumes and completes when ready returns.
//   4 TIMEOUT_CYCLES=16, req1 sends 1 byte then drops valid -> err_timeout pulse 16
//     cycles later, grant=0; pending req0 granted on following arbitration.
//   5 reset asserted mid-packet from req1 -> txd_start=0, busy=0 next cycle; with
//     both valid after reset, req0 granted first.
//   6 NUM_REQ=3, req2 single-byte packet 8'h5A (valid+last) -> one txd_start with
//     5A, pkt_done pulse, req_ready[2] high exactly one cycle.

Source files
------------

// File: rtl/txd_arbiter.sv
// Round-robin arbiter sharing one byte transmitter between NUM_REQ packet sources.
// Grant is held for a whole packet; a stalled owner is dropped after TIMEOUT_CYCLES.
module txd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 txd_ready_next,
   output logic                 txd_start,
   output logic [7:0]           txd_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 pkt_done,
   output logic                 err_timeout
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] last_grant;
   logic          eop;
   logic [CW-1:0] cnt;

   logic          any_req;
   logic [IW-1:0] winner;
   logic          g_valid;
   logic          g_last;
   logic [7:0]    g_data;
   logic          accept;

   // Rotating priority: first requester after the previous owner wins.
   always_comb begin
      int idx;
      any_req = 1'b0;
      winner  = last_grant;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_req && req_valid[idx[IW-1:0]]) begin
            any_req = 1'b1;
            winner  = idx[IW-1:0];
         end
      end
   end

   // last_grant doubles as the index of the current owner while busy.
   assign g_valid   = req_valid[last_grant];
   assign g_last    = req_last[last_grant];
   assign g_data    = req_data[{last_grant, 3'b000} +: 8];
   assign accept    = (state == ST_SEND) && g_valid && txd_ready_next;
   assign req_ready = accept ? grant : '0;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         last_grant  <= IW'(NUM_REQ - 1);
         eop         <= 1'b0;
         cnt         <= '0;
         txd_start   <= 1'b0;
         txd_data    <= 8'h00;
         pkt_done    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         txd_start   <= 1'b0;
         pkt_done    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               eop <= 1'b0;
               if (any_req) begin
                  grant      <= NUM_REQ'(1) << winner;
                  last_grant <= winner;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (accept) begin
                  txd_data  <= g_data;
                  txd_start <= 1'b1;
                  cnt       <= '0;
                  eop       <= g_last;
                  state     <= ST_GAP;
               end else if (TIMEOUT_CYCLES != 0 && txd_ready_next && !g_valid) begin
                  // Only source starvation counts; transmitter back-pressure never does.
                  if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                     err_timeout <= 1'b1;
                     grant       <= '0;
                     state       <= ST_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (eop) begin
                  pkt_done <= 1'b1;
                  grant    <= '0;
                  state    <= ST_IDLE;
               end else begin
                  state <= ST_SEND;
               end
            end
            default: begin
               grant <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_txd_arbiter.sv
// Directed bench for txd_arbiter: queue-driven requesters and an output monitor,
// with each scenario task checking transmitted bytes, pulses and grant state.
module tb_txd_arbiter;
   localparam int NR = 3;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [8*NR-1:0]   req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              txd_ready_next;
   logic              txd_start;
   logic [7:0]        txd_data;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              pkt_done;
   logic              err_timeout;

   always #5 clk = ~clk;

   txd_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .txd_ready_next(txd_ready_next),
      .txd_start(txd_start), .txd_data(txd_data), .grant(grant), .busy(busy),
      .pkt_done(pkt_done), .err_timeout(err_timeout)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [8:0]    srcq [NR][$];
   logic [NR-1:0] rdy_q = '0;
   logic [7:0]    out_dat [$];
   int            out_cyc [$];
   int            pd_cnt, pd_cyc, to_cnt, to_cyc;
   logic [NR-1:0] to_grant;
   int            rdy_cnt [NR];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: inputs change only at posedge+1, so negedge values are the edge values.
   always @(negedge clk) begin
      rdy_q = req_ready & req_valid;
      if (txd_start) begin
         out_dat.push_back(txd_data);
         out_cyc.push_back(cyc);
      end
      if (pkt_done) begin pd_cnt++; pd_cyc = cyc; end
      if (err_timeout) begin to_cnt++; to_cyc = cyc; to_grant = grant; end
      for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
   end

   // Requesters: pop an accepted byte, then present the head of each queue.
   always @(posedge clk) begin
      logic [NR-1:0]   v, l;
      logic [8*NR-1:0] d;
      logic [8:0]      h;
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (rdy_q[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
         if (srcq[i].size() != 0) begin
            h = srcq[i][0];
            v[i] = 1'b1;
            l[i] = h[8];
            d[8*i +: 8] = h[7:0];
         end
      end
      req_valid = v;
      req_last  = l;
      req_data  = d;
   end

   function automatic bit qempty();
      for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [63:0] outs();
      logic [63:0] r = '0;
      foreach (out_dat[i]) r = {r[55:0], out_dat[i]};
      return r;
   endfunction

   task automatic clr();
      out_dat.delete();
      out_cyc.delete();
      pd_cnt = 0; to_cnt = 0;
      for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
   endtask

   task automatic flush();
      for (int i = 0; i < NR; i++) srcq[i].delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy || !qempty()) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic wait_out(input int cnt, input int budget);
      int n = 0;
      while (out_dat.size() < cnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_out: got %0d bytes, required %0d", out_dat.size(), cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      txd_ready_next = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      repeat (2) @(negedge clk);
      checks += 6;
      if (txd_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", txd_start); end
      if (txd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", txd_data); end
      if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
      reset = 1'b0;
   endtask

   task automatic test_single_packet();
      clr();
      srcq[0].push_back(9'h0A1); srcq[0].push_back(9'h0A2); srcq[0].push_back(9'h1A3);
      wait_idle(100);
      checks += 5;
      if (outs() !== 64'hA1A2A3) begin errors++; $display("FAIL pkt_bytes: got %h want a1a2a3", outs()); end
      if (out_cyc.size() != 3 || out_cyc[1] - out_cyc[0] != 2 || out_cyc[2] - out_cyc[1] != 2) begin
         errors++; $display("FAIL pkt_spacing: %0d starts, required 3 starts 2 cycles apart", out_cyc.size());
      end
      if (pd_cnt !== 1) begin errors++; $display("FAIL pkt_done_cnt: got %0d want 1", pd_cnt); end
      if (out_cyc.size() != 3 || pd_cyc - out_cyc[2] != 1) begin
         errors++; $display("FAIL pkt_done_lat: got cycle %0d, required 1 after last start", pd_cyc);
      end
      if (grant !== '0) begin errors++; $display("FAIL pkt_grant_end: got %b want 0", grant); end
   endtask

   task automatic test_round_robin();
      do_reset();
      clr();
      srcq[0].push_back(9'h010); srcq[0].push_back(9'h111);
      srcq[1].push_back(9'h020); srcq[1].push_back(9'h121);
      wait_idle(100);
      checks += 2;
      if (outs() !== 64'h10112021) begin errors++; $display("FAIL rr_order: got %h want 10112021", outs()); end
      if (pd_cnt !== 2) begin errors++; $display("FAIL rr_pkt_done: got %0d want 2", pd_cnt); end
      clr();
      srcq[0].push_back(9'h130);
      wait_idle(100);
      srcq[0].push_back(9'h140);
      srcq[1].push_back(9'h150);
      wait_idle(100);
      checks++;
      if (outs() !== 64'h305040) begin errors++; $display("FAIL rr_rotate: got %h want 305040", outs()); end
   endtask

   task automatic test_backpressure();
      clr();
      srcq[0].push_back(9'h060); srcq[0].push_back(9'h061); srcq[0].push_back(9'h162);
      wait_out(1, 20);
      txd_ready_next = 1'b0;
      repeat (50) @(negedge clk);
      checks += 3;
      if (out_dat.size() != 1) begin errors++; $display("FAIL bp_hold: got %0d bytes want 1", out_dat.size()); end
      if (to_cnt !== 0) begin errors++; $display("FAIL bp_no_timeout: got %0d want 0", to_cnt); end
      if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
      txd_ready_next = 1'b1;
      wait_idle(100);
      checks += 2;
      if (outs() !== 64'h606162) begin errors++; $display("FAIL bp_bytes: got %h want 606162", outs()); end
      if (to_cnt !== 0) begin errors++; $display("FAIL bp_no_timeout2: got %0d want 0", to_cnt); end
   endtask

   task automatic test_timeout();
      clr();
      srcq[1].push_back(9'h070);
      srcq[0].push_back(9'h180);
      wait_idle(200);
      checks += 4;
      if (outs() !== 64'h7080) begin errors++; $display("FAIL to_bytes: got %h want 7080", outs()); end
      if (to_cnt !== 1) begin errors++; $display("FAIL to_count: got %0d want 1", to_cnt); end
      if (out_cyc.size() == 0 || to_cyc - out_cyc[0] != TO + 1) begin
         errors++; $display("FAIL to_latency: got %0d want %0d", to_cyc - (out_cyc.size() ? out_cyc[0] : 0), TO + 1);
      end
      if (to_grant !== '0) begin errors++; $display("FAIL to_grant: got %b want 0", to_grant); end
   endtask

   task automatic test_reset_mid();
      clr();
      srcq[1].push_back(9'h090); srcq[1].push_back(9'h091); srcq[1].push_back(9'h192);
      wait_out(1, 20);
      reset = 1'b1;
      flush();
      @(negedge clk);
      checks += 3;
      if (txd_start !== 1'b0) begin errors++; $display("FAIL rm_start: got %b want 0", txd_start); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
      if (grant !== '0) begin errors++; $display("FAIL rm_grant: got %b want 0", grant); end
      reset = 1'b0;
      clr();
      srcq[0].push_back(9'h1A0);
      srcq[1].push_back(9'h1B0);
      wait_idle(100);
      checks++;
      if (outs() !== 64'hA0B0) begin errors++; $display("FAIL rm_order: got %h want a0b0", outs()); end
   endtask

   task automatic test_single_byte_req2();
      clr();
      srcq[2].push_back(9'h15A);
      wait_idle(100);
      checks += 3;
      if (outs() !== 64'h5A) begin errors++; $display("FAIL sb_bytes: got %h want 5a", outs()); end
      if (pd_cnt !== 1) begin errors++; $display("FAIL sb_pkt_done: got %0d want 1", pd_cnt); end
      if (rdy_cnt[2] !== 1) begin errors++; $display("FAIL sb_ready_cycles: got %0d want 1", rdy_cnt[2]); end
   endtask

   initial begin
      pd_cnt = 0; pd_cyc = 0; to_cnt = 0; to_cyc = 0; to_grant = '0;
      for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_single_byte_req2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
